pc_next_unit: RTL
=================

# pc_next_unit

Program-counter sequencing block at the fetch end of the single-cycle/pipelined RISC-V datapath. Holds the architectural PC and computes the fall-through address. Consumes the EX-stage branch decision (`branch`, `zero`, `jump`) and the branch target, and produces the next fetch address, a one-cycle pipeline flush and redirect status. It replaces the free-standing 2:1 next-PC select with a registered, stall-aware redirect path.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hold PC (hazard unit).
- `branch`  input  1  EX instruction is a conditional branch.
- `zero`  input  1  ALU zero flag of the EX instruction.
- `jump`  input  1  EX instruction is an unconditional jump.
- `ex_pc`  input  XLEN  PC of the EX instruction.
- `imm`  input  XLEN  sign-extended branch/jump offset.
- `pc`  output  XLEN  current fetch address (registered).
- `pc_plus4`  output  XLEN  `pc + 4` (combinational from `pc`).
- `flush`  output  1  squash wrong-path IF/ID instructions.
- `taken`  output  1  redirect accepted this cycle (combinational).
- `misalign`  output  1  taken target not word-aligned (registered pulse).

One clock; reset is asynchronous and active-low.

## Operation
- Redirect condition: `take = jump | (branch & zero)`, evaluated only in state RUN.
- Target: `tgt = ex_pc + imm`, modulo 2^XLEN (carry discarded, wraps).
- Fall-through: `pc_plus4 = pc + 4`, wraps 0xFFFF_FFFC -> 0x0000_0000.
- States:
  - RUN: normal sequencing. Exits to FLUSH or TRAP.
  - FLUSH: one cycle. Decision inputs are ignored because they belong to a squashed instruction. Always returns to RUN.
  - TRAP: only present with the macro. Absorbing until reset.
- RUN, next PC priority:
  1. `take` -> `pc <= tgt`, go to FLUSH (overrides `stall`).
  2. `stall` -> hold `pc`.
  3. Otherwise -> `pc <= pc_plus4`.
- FLUSH: `pc <= stall ? pc : pc_plus4`. `take` is forced to 0.
- `taken` = `take` in RUN, else 0.

## Timing
- Reset (asynchronous assert, synchronous release on next edge):
  - `pc = RESET_PC`, state RUN.
  - `flush = 0`, `misalign = 0`, `taken = 0`.
  - `pc_plus4 = RESET_PC + 4`.
- Decision is sampled in cycle N. `pc` shows the target in cycle N+1. `flush` is high for exactly cycle N+1.
- Redirect latency is 1 cycle. Back-to-back redirects are impossible: the minimum spacing between two `taken` pulses is 2 cycles.
- `stall` high in cycle N+1 (FLUSH): `flush` still lasts exactly one cycle and the PC holds the target.
- Reset asserted mid-FLUSH or in TRAP: immediate return to the reset values; no residual flush.

## Configuration
`PC_MISALIGN_TRAP_EN`:
- Defined:
  - A taken redirect with `tgt[1:0] != 2'b00` does not load the PC.
  - Next cycle: `misalign` = 1 for one cycle, `flush` = 1 for one cycle, state -> TRAP.
  - In TRAP, `pc` is frozen and all inputs are ignored until reset.
- Undefined:
  - `tgt[1:0]` is forced to `2'b00` before loading.
  - `misalign` is tied to 0.
  - TRAP state is absent.

## Test plan
- Reset with `RESET_PC`=0x100, 3 idle cycles -> `pc` = 0x100, 0x104, 0x108, 0x10C; `flush` = 0 throughout.
- `branch`=1, `zero`=1, `ex_pc`=0x200, `imm`=0xFFFF_FFF0 -> `taken`=1; next cycle `pc`=0x1F0, `flush`=1 for one cycle; then `pc`=0x1F4.
- `branch`=1, `zero`=0 together with `stall`=1 -> no redirect, `pc` held. Then `jump`=1 with `stall`=1, `ex_pc`=0x40, `imm`=8 -> `pc`=0x48 (redirect beats stall).
- Decision inputs asserted during the FLUSH cycle (`jump`=1, `imm`=0x1000) -> ignored; `pc` = target+4; `taken`=0.
- `pc`=0xFFFF_FFFC, idle -> `pc`=0x0000_0000. `ex_pc`=0xFFFF_FFF0, `imm`=0x20, `jump`=1 -> `pc`=0x10.
- `jump`=1, `tgt`=0x102:
  - Macro defined -> `misalign`=1 and `flush`=1 for one cycle, `pc` frozen at pre-jump value until `reset_n` pulse.
  - Macro undefined -> `pc`=0x100, `misalign`=0.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter sequencer: holds the fetch PC, applies EX-stage redirects and raises a one-cycle flush.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being word-aligned.
module pc_next_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            taken,
  output logic            misalign
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
`ifdef PC_MISALIGN_TRAP_EN
    ,
    TRAP  = 2'd2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt;
  logic            take;
  logic            flush_q, flush_d;
  logic            misalign_d;

  assign tgt      = ex_pc + imm;
  assign take     = jump | (branch & zero);
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign flush    = flush_q;

  // Next-state, next-PC and registered-pulse selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    taken      = 1'b0;
    case (state_q)
      RUN: begin
        taken = take;
        if (take) begin
`ifdef PC_MISALIGN_TRAP_EN
          flush_d = 1'b1;
          if (tgt[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            pc_d    = tgt;
            state_d = FLUSH;
          end
`else
          pc_d    = {tgt[XLEN-1:2], 2'b00};
          flush_d = 1'b1;
          state_d = FLUSH;
`endif
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      // Decision inputs here belong to a squashed instruction
      FLUSH: begin
        state_d = RUN;
        if (!stall) pc_d = pc_plus4;
      end
`ifdef PC_MISALIGN_TRAP_EN
      TRAP: begin
        state_d = TRAP;
      end
`endif
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_d;
  assign misalign        = 1'b0;
`endif

endmodule
